// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared constants and type definitions for the TLB refill controller.
// The constants are the default geometry. Instances may override them through parameters.
package tlb_refill_ctrl_pkg;

    localparam int unsigned OFFSET         = 12;
    localparam int unsigned TLB_SIZE       = 4;
    localparam int unsigned PHYS_ADDR_SIZE = 20;
    localparam int unsigned PTE_VALID_BIT  = 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_ACK,
        S_FAULT
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Memory read port and TLB write port of the refill controller.
// The controller is the master. Memory and the two TLBs are on the slave side.
interface tlb_refill_ctrl_if #(
    parameter int unsigned OFFSET         = tlb_refill_ctrl_pkg::OFFSET,
    parameter int unsigned TLB_SIZE       = tlb_refill_ctrl_pkg::TLB_SIZE,
    parameter int unsigned PHYS_ADDR_SIZE = tlb_refill_ctrl_pkg::PHYS_ADDR_SIZE
);

    localparam int unsigned VPN_W = 32 - OFFSET;
    localparam int unsigned PPN_W = PHYS_ADDR_SIZE - OFFSET;
    localparam int unsigned IDX_W = $clog2(TLB_SIZE);

    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic              mem_valid;
    logic [31:0]       mem_data;

    logic [1:0]        tlb_we;
    logic [IDX_W-1:0]  tlb_windex;
    logic [VPN_W-1:0]  tlb_wvpn;
    logic [PPN_W-1:0]  tlb_wppn;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_valid,
        input  mem_data,
        output tlb_we,
        output tlb_windex,
        output tlb_wvpn,
        output tlb_wppn
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_valid,
        output mem_data,
        input  tlb_we,
        input  tlb_windex,
        input  tlb_wvpn,
        input  tlb_wppn
    );

endinterface

// File: rtl/tlb_refill_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter. Bit 0 is the I side and bit 1 is the D side.
// The last grant is remembered only when a grant is actually taken (en_i).
module rr_arbiter2
    import tlb_refill_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    side_t      last_q;
    side_t      last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == SIDE_D) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
        if (en_i && (req_i != 2'b00)) begin
            last_d = gnt[1] ? SIDE_D : SIDE_I;
        end
    end

    assign gnt_o = gnt;

    // Resetting to D makes the I side win the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= SIDE_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller. It walks a single-level page table for I-TLB and D-TLB misses.
// It writes the translated entry into the requesting TLB at a FIFO slot, then acks or faults.
module tlb_refill_ctrl
    import tlb_refill_ctrl_pkg::*;
#(
    parameter int unsigned OFFSET         = tlb_refill_ctrl_pkg::OFFSET,
    parameter int unsigned TLB_SIZE       = tlb_refill_ctrl_pkg::TLB_SIZE,
    parameter int unsigned PHYS_ADDR_SIZE = tlb_refill_ctrl_pkg::PHYS_ADDR_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                imiss_i,
    input  logic [31-OFFSET:0]  imiss_vpn_i,
    input  logic                dmiss_i,
    input  logic [31-OFFSET:0]  dmiss_vpn_i,
    input  logic [31:0]         ptbr_i,
    tlb_refill_ctrl_if.master   mem_tlb_if,
    output logic                iack_o,
    output logic                dack_o,
    output logic                ifault_o,
    output logic                dfault_o,
    output logic                busy_o
);

    localparam int unsigned VPN_W = 32 - OFFSET;
    localparam int unsigned PPN_W = PHYS_ADDR_SIZE - OFFSET;
    localparam int unsigned IDX_W = $clog2(TLB_SIZE);

    state_t            state_q, state_d;
    side_t             side_q, side_d;
    logic [VPN_W-1:0]  vpn_q, vpn_d;
    logic [31:0]       ptbr_q, ptbr_d;
    logic [PPN_W-1:0]  ppn_q, ppn_d;
    logic [IDX_W-1:0]  iptr_q, iptr_d;
    logic [IDX_W-1:0]  dptr_q, dptr_d;

    logic [1:0]        gnt;
    state_t            pte_state;

    rr_arbiter2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({dmiss_i, imiss_i}),
        .en_i  (state_q == S_IDLE),
        .gnt_o (gnt)
    );

    // Only the valid bit and the ppn field of the PTE matter.
    assign pte_state = mem_tlb_if.mem_data[PTE_VALID_BIT] ? S_WRITE : S_FAULT;

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        vpn_d   = vpn_q;
        ptbr_d  = ptbr_q;
        ppn_d   = ppn_q;
        iptr_d  = iptr_q;
        dptr_d  = dptr_q;

        mem_tlb_if.mem_req    = 1'b0;
        mem_tlb_if.mem_addr   = '0;
        mem_tlb_if.tlb_we     = '0;
        mem_tlb_if.tlb_windex = '0;
        mem_tlb_if.tlb_wvpn   = '0;
        mem_tlb_if.tlb_wppn   = '0;
        iack_o   = 1'b0;
        dack_o   = 1'b0;
        ifault_o = 1'b0;
        dfault_o = 1'b0;
        busy_o   = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    side_d  = gnt[1] ? SIDE_D : SIDE_I;
                    vpn_d   = gnt[1] ? dmiss_vpn_i : imiss_vpn_i;
                    ptbr_d  = ptbr_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_tlb_if.mem_req  = 1'b1;
                mem_tlb_if.mem_addr = ptbr_q + 32'({vpn_q, 2'b00});
                if (mem_tlb_if.mem_ack) begin
                    state_d = S_WAIT;
                    // A response arriving together with the ack skips WAIT.
                    if (mem_tlb_if.mem_valid) begin
                        ppn_d   = mem_tlb_if.mem_data[PPN_W-1:0];
                        state_d = pte_state;
                    end
                end
            end
            S_WAIT: begin
                if (mem_tlb_if.mem_valid) begin
                    ppn_d   = mem_tlb_if.mem_data[PPN_W-1:0];
                    state_d = pte_state;
                end
            end
            S_WRITE: begin
                mem_tlb_if.tlb_wvpn = vpn_q;
                mem_tlb_if.tlb_wppn = ppn_q;
                if (side_q == SIDE_D) begin
                    mem_tlb_if.tlb_we     = 2'b10;
                    mem_tlb_if.tlb_windex = dptr_q;
                    dptr_d                = dptr_q + 1'b1;
                end else begin
                    mem_tlb_if.tlb_we     = 2'b01;
                    mem_tlb_if.tlb_windex = iptr_q;
                    iptr_d                = iptr_q + 1'b1;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                iack_o  = (side_q == SIDE_I);
                dack_o  = (side_q == SIDE_D);
                state_d = S_IDLE;
            end
            S_FAULT: begin
                ifault_o = (side_q == SIDE_I);
                dfault_o = (side_q == SIDE_D);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            side_q  <= SIDE_I;
            vpn_q   <= '0;
            ptbr_q  <= '0;
            ppn_q   <= '0;
            iptr_q  <= '0;
            dptr_q  <= '0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            vpn_q   <= vpn_d;
            ptbr_q  <= ptbr_d;
            ppn_q   <= ppn_d;
            iptr_q  <= iptr_d;
            dptr_q  <= dptr_d;
        end
    end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Scoreboard bench for tlb_refill_ctrl: expected PTE addresses, TLB writes and ack/fault
// events are queued when a miss is launched and compared when the DUT produces them.
module tb_tlb_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imiss, dmiss;
    logic [19:0] imiss_vpn, dmiss_vpn;
    logic [31:0] ptbr;
    logic        iack, dack, ifault, dfault, busy;

    always #5 clk = ~clk;

    tlb_refill_ctrl_if #(.OFFSET(12), .TLB_SIZE(4), .PHYS_ADDR_SIZE(20)) bus ();

    tlb_refill_ctrl #(.OFFSET(12), .TLB_SIZE(4), .PHYS_ADDR_SIZE(20)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .imiss_i     (imiss),
        .imiss_vpn_i (imiss_vpn),
        .dmiss_i     (dmiss),
        .dmiss_vpn_i (dmiss_vpn),
        .ptbr_i      (ptbr),
        .mem_tlb_if  (bus),
        .iack_o      (iack),
        .dack_o      (dack),
        .ifault_o    (ifault),
        .dfault_o    (dfault),
        .busy_o      (busy)
    );

    typedef struct {
        logic [1:0]  we;
        logic [1:0]  idx;
        logic [19:0] vpn;
        logic [7:0]  ppn;
    } wr_t;

    logic [31:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    logic [3:0]  exp_ev_q[$];   // {dfault, ifault, dack, iack}
    logic [31:0] pte_q[$];

    logic [1:0]  iptr = '0;
    logic [1:0]  dptr = '0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int ack_dly = 0;
    int val_dly = 1;
    bit stray_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after ack_dly cycles and returns data val_dly cycles after the ack.
    initial begin
        int phase;
        int wcnt;
        int vcnt;
        phase = 0;
        wcnt  = 0;
        vcnt  = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_valid = 1'b0;
            if (rst) begin
                phase = 0;
            end else if (stray_valid) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = 32'h8000_00AB;
            end else begin
                if (phase == 0 && bus.mem_req) begin
                    phase = 1;
                    wcnt  = 0;
                end
                if (phase == 1) begin
                    if (wcnt == ack_dly) begin
                        bus.mem_ack = 1'b1;
                        if (val_dly == 0) begin
                            bus.mem_valid = 1'b1;
                            bus.mem_data  = (pte_q.size() != 0) ? pte_q.pop_front() : 32'h0;
                            phase = 0;
                        end else begin
                            vcnt  = val_dly;
                            phase = 2;
                        end
                    end else begin
                        wcnt++;
                    end
                end else if (phase == 2) begin
                    vcnt--;
                    if (vcnt == 0) begin
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = (pte_q.size() != 0) ? pte_q.pop_front() : 32'h0;
                        phase = 0;
                    end
                end
            end
        end
    end

    // Output monitor: compares every request address, TLB write and ack/fault pulse.
    initial begin
        logic        prev_req;
        logic [31:0] cur_addr;
        logic [3:0]  ev;
        wr_t         w;
        prev_req = 1'b0;
        cur_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (exp_addr_q.size() != 0) begin
                        cur_addr = exp_addr_q.pop_front();
                    end else begin
                        check_eq("req_unexp", 32'(bus.mem_req), 32'h0);
                        cur_addr = '0;
                    end
                end
                if (bus.mem_req) check_eq("mem_addr", bus.mem_addr, cur_addr);
                prev_req = bus.mem_req;

                if (bus.tlb_we != 2'b00) begin
                    if (exp_wr_q.size() != 0) begin
                        w = exp_wr_q.pop_front();
                        check_eq("tlb_we", 32'(bus.tlb_we), 32'(w.we));
                        check_eq("windex", 32'(bus.tlb_windex), 32'(w.idx));
                        check_eq("wvpn", 32'(bus.tlb_wvpn), 32'(w.vpn));
                        check_eq("wppn", 32'(bus.tlb_wppn), 32'(w.ppn));
                    end else begin
                        check_eq("wr_unexp", 32'(bus.tlb_we), 32'h0);
                    end
                end

                ev = {dfault, ifault, dack, iack};
                if (ev != 4'b0000) begin
                    if (exp_ev_q.size() != 0) check_eq("event", 32'(ev), 32'(exp_ev_q.pop_front()));
                    else                      check_eq("ev_unexp", 32'(ev), 32'h0);
                end
            end
        end
    end

    task automatic expect_walk(input int side, input logic [19:0] vpn,
                               input logic [31:0] base, input logic [31:0] pte);
        wr_t w;
        exp_addr_q.push_back(base + {10'b0, vpn, 2'b00});
        pte_q.push_back(pte);
        if (pte[31]) begin
            w.we  = (side != 0) ? 2'b10 : 2'b01;
            w.idx = (side != 0) ? dptr : iptr;
            w.vpn = vpn;
            w.ppn = pte[7:0];
            exp_wr_q.push_back(w);
            if (side != 0) dptr = dptr + 2'd1;
            else           iptr = iptr + 2'd1;
            exp_ev_q.push_back((side != 0) ? 4'b0010 : 4'b0001);
        end else begin
            exp_ev_q.push_back((side != 0) ? 4'b1000 : 4'b0100);
        end
    endtask

    task automatic wait_done(input int side, input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (side != 0) seen = dack | dfault;
            else           seen = iack | ifault;
        end
        check_eq({tag, "_done"}, 32'(seen), 32'h1);
    endtask

    task automatic single_miss(input int side, input logic [19:0] vpn, input logic [31:0] pte,
                               input int ad, input int vd, input string tag);
        int cyc;
        @(negedge clk);
        ack_dly = ad;
        val_dly = vd;
        expect_walk(side, vpn, ptbr, pte);
        if (side != 0) begin dmiss = 1'b1; dmiss_vpn = vpn; end
        else           begin imiss = 1'b1; imiss_vpn = vpn; end
        wait_done(side, tag, cyc);
        imiss = 1'b0;
        dmiss = 1'b0;
        check_eq({tag, "_lat"}, 32'(cyc), 32'(ad + vd + (pte[31] ? 3 : 2)));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        imiss = 1'b0;
        dmiss = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        iptr = '0;
        dptr = '0;
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_ev_q.delete();
        pte_q.delete();
    endtask

    initial begin
        int cyc;
        rst = 1'b1; imiss = 1'b0; dmiss = 1'b0;
        imiss_vpn = '0; dmiss_vpn = '0; ptbr = 32'h0010_0000;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_outs", 32'({bus.mem_req, bus.tlb_we, iack, dack, ifault, dfault}), 32'h0);
        check_eq("rst_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;

        // Basic I-side refill
        single_miss(0, 20'h00012, 32'h8000_0345, 0, 1, "i_basic");
        @(negedge clk);
        check_eq("busy_idle", 32'(busy), 32'h0);

        // Simultaneous misses after reset: I first, then D
        do_reset();
        @(negedge clk);
        ack_dly = 0; val_dly = 1;
        expect_walk(0, 20'h00A01, ptbr, 32'h8000_0011);
        expect_walk(1, 20'h00B02, ptbr, 32'h8000_0022);
        imiss = 1'b1; imiss_vpn = 20'h00A01;
        dmiss = 1'b1; dmiss_vpn = 20'h00B02;
        @(negedge clk);
        check_eq("busy_walk", 32'(busy), 32'h1);
        wait_done(0, "tie_i", cyc);
        imiss = 1'b0;
        wait_done(1, "tie_d", cyc);
        dmiss = 1'b0;

        // Five D refills wrap the D pointer, then the I pointer is still 0
        do_reset();
        for (int i = 0; i < 5; i++)
            single_miss(1, 20'h00100 + 20'(i), 32'h8000_0050 + 32'(i), 0, 1, "d_seq");
        single_miss(0, 20'h00200, 32'h8000_0061, 0, 1, "i_after_d");

        // Fault leaves the D pointer at 1
        single_miss(1, 20'h00300, 32'h0000_0345, 0, 1, "d_fault");
        single_miss(1, 20'h00301, 32'h8000_0070, 0, 2, "d_after_fault");

        // Held-off ack with ptbr changing mid-walk: request and address must stay stable
        @(negedge clk);
        ack_dly = 5; val_dly = 1;
        expect_walk(0, 20'h0FFFF, ptbr, 32'h8000_00C3);
        imiss = 1'b1; imiss_vpn = 20'h0FFFF;
        @(negedge clk);
        ptbr = 32'hFFFF_0000;
        wait_done(0, "ack_hold", cyc);
        imiss = 1'b0;
        check_eq("ack_hold_lat", 32'(cyc + 1), 32'(5 + 1 + 3));

        // Ack and valid together, address wrap, upper PTE bits ignored
        ptbr = 32'hFFFF_FFF0;
        single_miss(0, 20'h00010, 32'hFFFF_FF5A, 0, 0, "same_cyc");
        ptbr = 32'h0010_0000;

        // Miss dropped during the walk still completes
        @(negedge clk);
        ack_dly = 1; val_dly = 1;
        expect_walk(0, 20'h00777, ptbr, 32'h8000_0088);
        imiss = 1'b1; imiss_vpn = 20'h00777;
        @(negedge clk);
        imiss = 1'b0;
        wait_done(0, "drop_early", cyc);

        // Last grant was I, so a tie now goes to D first
        @(negedge clk);
        ack_dly = 0; val_dly = 1;
        expect_walk(1, 20'h00D0D, ptbr, 32'h8000_0091);
        expect_walk(0, 20'h00E0E, ptbr, 32'h8000_0092);
        imiss = 1'b1; imiss_vpn = 20'h00E0E;
        dmiss = 1'b1; dmiss_vpn = 20'h00D0D;
        wait_done(1, "rr_d", cyc);
        dmiss = 1'b0;
        wait_done(0, "rr_i", cyc);
        imiss = 1'b0;

        // Reset during WAIT
        @(negedge clk);
        ack_dly = 0; val_dly = 20;
        expect_walk(1, 20'h0ABCD, ptbr, 32'h8000_0077);
        dmiss = 1'b1; dmiss_vpn = 20'h0ABCD;
        repeat (3) @(negedge clk);
        check_eq("wait_busy", 32'(busy), 32'h1);
        check_eq("wait_noreq", 32'(bus.mem_req), 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_outs", 32'({busy, bus.mem_req, bus.tlb_we, iack, dack, ifault, dfault}), 32'h0);
        check_eq("arst_addr", bus.mem_addr, 32'h0);
        dmiss = 1'b0;
        exp_wr_q.delete();
        exp_ev_q.delete();
        pte_q.delete();
        iptr = '0;
        dptr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2 stray_valid = 1'b1;
        @(negedge clk);
        #2 stray_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("stray_idle", 32'(busy), 32'h0);
        single_miss(1, 20'h00042, 32'h8000_00A5, 0, 1, "post_rst");

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(exp_addr_q.size() + exp_wr_q.size() + exp_ev_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
